// File: rtl/run_monitor_pkg.sv
// Shared types for the run supervisor: FSM phase and end-of-run cause encoding.
package run_monitor_pkg;

  typedef enum logic [1:0] {HOLD, RUN, DONE} rm_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_TIMEOUT,
    CAUSE_STALL,
    CAUSE_HALT
  } cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_monitor.sv
// Run supervisor for the multicycle core: reset pulse, run/transition/stall counting, sticky done + cause.
// Define RUN_MONITOR_HIST_EN to add per-state entry counters read through hist_sel/hist_count.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int STATE_WIDTH = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 64,
  parameter int RST_HOLD    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state_in,
  input  logic                   halt_req,
  input  logic                   clear,
`ifdef RUN_MONITOR_HIST_EN
  input  logic [STATE_WIDTH-1:0] hist_sel,
  output logic [CNT_WIDTH-1:0]   hist_count,
`endif
  output logic                   core_reset,
  output logic                   running,
  output logic                   done,
  output logic [1:0]             done_cause,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [CNT_WIDTH-1:0]   trans_count,
  output logic [STATE_WIDTH-1:0] last_state
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  rm_state_t              state_q, state_d;
  cause_t                 cause_q, cause_d;
  logic [STATE_WIDTH-1:0] last_q, last_d;
  logic [HW-1:0]          hold_cnt;
  logic [CNT_WIDTH-1:0]   cyc_cnt, trans_cnt, stall_cnt;
  logic [CNT_WIDTH-1:0]   cyc_nxt, stall_nxt;
  logic                   in_run, first_cyc, changed, hit_timeout, hit_stall;

  // cycle_count only reads zero on the first RUN cycle, so it doubles as the "no previous state" flag
  assign in_run    = (state_q == RUN);
  assign first_cyc = (cyc_cnt == '0);
  assign changed   = in_run && !first_cyc && (state_in != last_q);

  assign cyc_nxt     = (cyc_cnt == {CNT_WIDTH{1'b1}}) ? cyc_cnt : cyc_cnt + 1'b1;
  assign stall_nxt   = changed ? '0 :
                       ((stall_cnt == {CNT_WIDTH{1'b1}}) ? stall_cnt : stall_cnt + 1'b1);
  assign hit_timeout = (MAX_CYCLES != 0) && (32'(cyc_nxt) == 32'(MAX_CYCLES));
  assign hit_stall   = (STALL_LIMIT != 0) && (32'(stall_nxt) == 32'(STALL_LIMIT));

  sat_counter #(.WIDTH(HW)) u_hold (
    .clk(clk), .reset(reset), .clr_i(clear || (state_q != HOLD)),
    .inc_i(state_q == HOLD), .count_o(hold_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(in_run), .count_o(cyc_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_trans (
    .clk(clk), .reset(reset), .clr_i(clear), .inc_i(changed), .count_o(trans_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk(clk), .reset(reset), .clr_i(clear || changed), .inc_i(in_run), .count_o(stall_cnt)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    last_d  = last_q;
    if (clear) begin
      state_d = HOLD;
      cause_d = CAUSE_NONE;
      last_d  = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt == HW'(RST_HOLD - 1)) state_d = RUN;
        end
        RUN: begin
          last_d = state_in;
          if (halt_req) begin
            state_d = DONE;
            cause_d = CAUSE_HALT;
          end else if (hit_timeout) begin
            state_d = DONE;
            cause_d = CAUSE_TIMEOUT;
          end else if (hit_stall) begin
            state_d = DONE;
            cause_d = CAUSE_STALL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      cause_q <= CAUSE_NONE;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      last_q  <= last_d;
    end
  end

`ifdef RUN_MONITOR_HIST_EN
  localparam int NS = 1 << STATE_WIDTH;

  logic [CNT_WIDTH-1:0] hist_cnt [NS];
  logic                 hist_hit;

  // A state is "entered" on every transition and also on the very first RUN cycle
  assign hist_hit = in_run && (first_cyc || changed);

  for (genvar g = 0; g < NS; g++) begin : g_hist
    sat_counter #(.WIDTH(CNT_WIDTH)) u_hist (
      .clk(clk), .reset(reset), .clr_i(clear),
      .inc_i(hist_hit && (state_in == STATE_WIDTH'(g))), .count_o(hist_cnt[g])
    );
  end

  assign hist_count = hist_cnt[hist_sel];
`endif

  assign core_reset  = (state_q != RUN);
  assign running     = in_run;
  assign done        = (state_q == DONE);
  assign done_cause  = cause_q;
  assign cycle_count = cyc_cnt;
  assign trans_count = trans_cnt;
  assign last_state  = last_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: queue-based run-history model checked every cycle, plus directed literal checks.
module tb_run_monitor;

  localparam int CW    = 16;
  localparam int SW    = 4;
  localparam int MAXC  = 10;
  localparam int STALLL = 5;
  localparam int RH    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halt_req = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] state_in = '0;
  logic          core_reset, running, done;
  logic [1:0]    done_cause;
  logic [CW-1:0] cycle_count, trans_count;
  logic [SW-1:0] last_state;
`ifdef RUN_MONITOR_HIST_EN
  logic [SW-1:0] hist_sel = '0;
  logic [CW-1:0] hist_count;
`endif

  run_monitor #(
    .CNT_WIDTH(CW), .STATE_WIDTH(SW), .MAX_CYCLES(MAXC), .STALL_LIMIT(STALLL), .RST_HOLD(RH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state_in(state_in),
    .halt_req(halt_req),
    .clear(clear),
`ifdef RUN_MONITOR_HIST_EN
    .hist_sel(hist_sel),
    .hist_count(hist_count),
`endif
    .core_reset(core_reset),
    .running(running),
    .done(done),
    .done_cause(done_cause),
    .cycle_count(cycle_count),
    .trans_count(trans_count),
    .last_state(last_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the whole current run is kept as the list of state_in values seen in RUN.
  bit            m_run  = 1'b0;
  bit            m_done = 1'b0;
  int            m_hold = 0;
  int            m_cause = 0;
  logic [SW-1:0] m_q[$];

  function automatic int m_trans();
    int t = 0;
    for (int i = 1; i < m_q.size(); i++) if (m_q[i] != m_q[i-1]) t++;
    return t;
  endfunction

  function automatic int m_stall();
    int len = 0;
    int n = m_q.size();
    for (int i = n - 1; i >= 0; i--) begin
      if (m_q[i] == m_q[n-1]) len++;
      else break;
    end
    return (len == n) ? len : len - 1;
  endfunction

  function automatic int m_last();
    return (m_q.size() == 0) ? 0 : int'(m_q[m_q.size()-1]);
  endfunction

  function automatic int m_hist(input logic [SW-1:0] sel);
    int c = 0;
    for (int i = 0; i < m_q.size(); i++)
      if ((i == 0 || m_q[i] != m_q[i-1]) && m_q[i] == sel) c++;
    return c;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset || clear) begin
      m_run = 0; m_done = 0; m_hold = 0; m_cause = 0;
      m_q.delete();
    end else if (m_run) begin
      m_q.push_back(state_in);
      if (halt_req)                 m_cause = 3;
      else if (m_q.size() == MAXC)  m_cause = 1;
      else if (m_stall() == STALLL) m_cause = 2;
      if (m_cause != 0) begin
        m_run = 0;
        m_done = 1;
      end
    end else if (!m_done) begin
      m_hold++;
      if (m_hold == RH) begin
        m_run = 1;
        m_hold = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("cmp_core_reset", core_reset, !m_run);
    check("cmp_running", running, m_run);
    check("cmp_done", done, m_done);
    check("cmp_cause", done_cause, m_cause);
    check("cmp_cycle_count", cycle_count, m_q.size());
    check("cmp_trans_count", trans_count, m_trans());
    check("cmp_last_state", last_state, m_last());
`ifdef RUN_MONITOR_HIST_EN
    check("cmp_hist_count", hist_count, m_hist(hist_sel));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (running) begin
        ok = 1;
        break;
      end
      step();
    end
    check(name, ok, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_core_reset", core_reset, 1);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cycle", cycle_count, 0);
    reset = 1'b0;

    // Reset pulse to the core lasts RST_HOLD cycles after release
    step();
    check("hold_core_reset", core_reset, 1);
    check("hold_running", running, 0);
    step();
    check("run_entry_running", running, 1);
    check("run_entry_core_reset", core_reset, 0);
    check("run_entry_cycle", cycle_count, 0);
    state_in = 4'd0;
    step();
    check("run_first_cycle", cycle_count, 1);

    // Timeout with state toggling every cycle
    for (int i = 1; i < 40 && !done; i++) begin
      state_in = SW'(i % 2);
      step();
    end
    check("to_done", done, 1);
    check("to_cause", done_cause, 1);
    check("to_cycle", cycle_count, 10);
    check("to_trans", trans_count, 9);
    check("to_core_reset", core_reset, 1);

    // Clear restarts the run through HOLD
    do_clear();
    check("clr_done", done, 0);
    check("clr_cause", done_cause, 0);
    check("clr_cycle", cycle_count, 0);
    check("clr_trans", trans_count, 0);
    check("clr_core_reset", core_reset, 1);
    step();
    check("clr_hold2_running", running, 0);
    step();
    check("clr_run_running", running, 1);

    // Stall: constant state from the first RUN cycle
    state_in = 4'b0011;
    for (int i = 0; i < 40 && !done; i++) step();
    check("st_cause", done_cause, 2);
    check("st_cycle", cycle_count, 5);
    check("st_trans", trans_count, 0);
    check("st_last", last_state, 3);

    // Halt on the same cycle the timeout would fire
    do_clear();
    wait_running("halt_wait_run");
    for (int i = 0; i < MAXC; i++) begin
      state_in = SW'(i % 2);
      halt_req = (i == MAXC - 1);
      step();
    end
    halt_req = 1'b0;
    check("halt_cause", done_cause, 3);
    check("halt_cycle", cycle_count, 10);
    check("halt_core_reset", core_reset, 1);
    step();
    step();
    check("halt_frozen_cycle", cycle_count, 10);
    check("halt_frozen_trans", trans_count, 9);

    // Clear beats halt in the same cycle
    do_clear();
    wait_running("cvh_wait_run");
    step();
    halt_req = 1'b1;
    clear = 1'b1;
    step();
    halt_req = 1'b0;
    clear = 1'b0;
    check("cvh_done", done, 0);
    check("cvh_cause", done_cause, 0);

    // Asynchronous reset between clock edges
    wait_running("ar_wait_run");
    for (int i = 0; i < 3; i++) begin
      state_in = SW'(i);
      step();
    end
    #2 reset = 1'b1;
    #1;
    check("ar_running", running, 0);
    check("ar_core_reset", core_reset, 1);
    check("ar_cycle", cycle_count, 0);
    check("ar_trans", trans_count, 0);
    check("ar_last", last_state, 0);
    step();
    reset = 1'b0;

`ifdef RUN_MONITOR_HIST_EN
    wait_running("hist_wait_run");
    begin
      logic [SW-1:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd1};
      for (int i = 0; i < 5; i++) begin
        state_in = seq[i];
        halt_req = (i == 4);
        step();
      end
    end
    halt_req = 1'b0;
    hist_sel = 4'd1; #1 check("hist_1", hist_count, 2);
    hist_sel = 4'd0; #1 check("hist_0", hist_count, 1);
    hist_sel = 4'd2; #1 check("hist_2", hist_count, 1);
    hist_sel = 4'd3; #1 check("hist_3", hist_count, 0);
    step();
`endif

    // Randomised run: sticky states to provoke stalls, rare halts, clears and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) >= 7) state_in = SW'($urandom_range(0, 3));
      halt_req = ($urandom_range(0, 99) == 0);
      clear    = ($urandom_range(0, 39) == 0);
`ifdef RUN_MONITOR_HIST_EN
      hist_sel = SW'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      step();
    end
    halt_req = 1'b0;
    clear = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
